// File: rtl/pipeline_regs_pkg.sv
// Shared helpers for the stage-to-stage pipeline register.
// Occupancy width is derived here so parents can size their own wires identically.
package pipeline_regs_pkg;

  function automatic int occ_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid+data pipeline slot. Priority: reset > clear > hold > load.
// An invalid slot always carries BUBBLE, so downstream never sees stale payload.
module pipe_stage
  import pipeline_regs_pkg::*;
#(
  parameter int              WIDTH  = 64,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             hold,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d,
  output logic             q_valid,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      q_valid <= 1'b0;
      q       <= BUBBLE;
    end else if (!hold) begin
      q_valid <= d_valid;
      q       <= d_valid ? d : BUBBLE;
    end
  end

endmodule

// File: rtl/pipeline_regs.sv
// DEPTH-stage pipeline register with per-stage valid, global stall and flush.
// occupancy is a popcount of registered valid bits only, so it has no input path.
module pipeline_regs
  import pipeline_regs_pkg::*;
#(
  parameter int               WIDTH  = 64,
  parameter int               DEPTH  = 1,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  output logic [occ_bits(DEPTH)-1:0]  occupancy
);

  localparam int OW = occ_bits(DEPTH);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q   [DEPTH];
  logic [DEPTH-1:0] src_valid;
  logic [WIDTH-1:0] src_data [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_valid[k] = in_valid;
      assign src_data[k]  = in_data;
    end else begin : g_chain
      assign src_valid[k] = valid_q[k-1];
      assign src_data[k]  = data_q[k-1];
    end

    pipe_stage #(
      .WIDTH  (WIDTH),
      .BUBBLE (BUBBLE)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .clear   (flush),
      .hold    (stall),
      .d_valid (src_valid[k]),
      .d       (src_data[k]),
      .q_valid (valid_q[k]),
      .q       (data_q[k])
    );
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + OW'(valid_q[k]);
    end
  end

endmodule

// File: tb/tb_pipeline_regs.sv
// Directed bench for pipeline_regs: three instances (3x64, 2x32 with NOP bubble, 1x8).
module tb_pipeline_regs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance A: WIDTH=64, DEPTH=3, BUBBLE=0
  logic        a_reset, a_stall, a_flush, a_in_valid, a_out_valid;
  logic [63:0] a_in_data, a_out_data;
  logic [1:0]  a_occ;
  // instance B: WIDTH=32, DEPTH=2, BUBBLE=D503201F
  logic        b_reset, b_stall, b_flush, b_in_valid, b_out_valid;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_occ;
  // instance C: WIDTH=8, DEPTH=1, BUBBLE=5A
  logic        c_reset, c_stall, c_flush, c_in_valid, c_out_valid;
  logic [7:0]  c_in_data, c_out_data;
  logic [0:0]  c_occ;

  pipeline_regs #(.WIDTH(64), .DEPTH(3), .BUBBLE(64'h0)) ua (
    .clk(clk), .reset(a_reset), .stall(a_stall), .flush(a_flush),
    .in_valid(a_in_valid), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_data(a_out_data), .occupancy(a_occ));

  pipeline_regs #(.WIDTH(32), .DEPTH(2), .BUBBLE(32'hD503201F)) ub (
    .clk(clk), .reset(b_reset), .stall(b_stall), .flush(b_flush),
    .in_valid(b_in_valid), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_data(b_out_data), .occupancy(b_occ));

  pipeline_regs #(.WIDTH(8), .DEPTH(1), .BUBBLE(8'h5A)) uc (
    .clk(clk), .reset(c_reset), .stall(c_stall), .flush(c_flush),
    .in_valid(c_in_valid), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_data(c_out_data), .occupancy(c_occ));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [63:0] d, input int occ);
    chk({tag, ".valid"}, {63'd0, a_out_valid}, {63'd0, v});
    chk({tag, ".data"},  a_out_data, d);
    chk({tag, ".occ"},   {62'd0, a_occ}, 64'(occ));
  endtask

  task automatic chk_b(input string tag, input logic v, input logic [31:0] d, input int occ);
    chk({tag, ".valid"}, {63'd0, b_out_valid}, {63'd0, v});
    chk({tag, ".data"},  {32'd0, b_out_data}, {32'd0, d});
    chk({tag, ".occ"},   {62'd0, b_occ}, 64'(occ));
  endtask

  task automatic chk_c(input string tag, input logic v, input logic [7:0] d, input int occ);
    chk({tag, ".valid"}, {63'd0, c_out_valid}, {63'd0, v});
    chk({tag, ".data"},  {56'd0, c_out_data}, {56'd0, d});
    chk({tag, ".occ"},   {63'd0, c_occ}, 64'(occ));
  endtask

  task automatic push_a(input logic v, input logic [63:0] d);
    a_in_valid = v;
    a_in_data  = d;
  endtask

  initial begin
    a_reset = 1; a_stall = 0; a_flush = 0; a_in_valid = 1; a_in_data = 64'hAAAA_AAAA_AAAA_AAAA;
    b_reset = 1; b_stall = 0; b_flush = 0; b_in_valid = 0; b_in_data = 32'h0;
    c_reset = 1; c_stall = 0; c_flush = 0; c_in_valid = 0; c_in_data = 8'h0;

    // reset held two edges while input is presented
    tick(); chk_a("rst1", 0, 64'h0, 0);
    tick(); chk_a("rst2", 0, 64'h0, 0);
    a_reset = 0;

    // streaming 1,2,3,4 then drain
    push_a(1, 64'd1); tick(); chk_a("str1", 0, 64'h0, 1);
    push_a(1, 64'd2); tick(); chk_a("str2", 0, 64'h0, 2);
    push_a(1, 64'd3); tick(); chk_a("str3", 1, 64'd1, 3);
    push_a(1, 64'd4); tick(); chk_a("str4", 1, 64'd2, 3);
    push_a(0, 64'h0); tick(); chk_a("str5", 1, 64'd3, 2);
    tick();                   chk_a("str6", 1, 64'd4, 1);
    tick();                   chk_a("str7", 0, 64'h0, 0);

    // stall: oldest 7 at output, 99 offered while stalled
    push_a(1, 64'd7); tick();
    push_a(1, 64'd6); tick();
    push_a(1, 64'd5); tick(); chk_a("stl_fill", 1, 64'd7, 3);
    a_stall = 1; push_a(1, 64'd99);
    for (int i = 0; i < 4; i++) begin
      tick(); chk_a($sformatf("stl_hold%0d", i), 1, 64'd7, 3);
    end
    a_stall = 0; push_a(0, 64'd99);
    tick(); chk_a("stl_rel1", 1, 64'd6, 2);
    tick(); chk_a("stl_rel2", 1, 64'd5, 1);
    tick(); chk_a("stl_rel3", 0, 64'h0, 0);

    // flush beats stall; the item offered on the flush edge is dropped
    push_a(1, 64'd1); tick();
    push_a(1, 64'd2); tick();
    push_a(1, 64'd3); tick(); chk_a("fl_fill", 1, 64'd1, 3);
    a_stall = 1; a_flush = 1; push_a(1, 64'h55);
    tick(); chk_a("fl_edge", 0, 64'h0, 0);
    a_stall = 0; a_flush = 0; push_a(1, 64'd8);
    tick(); chk_a("fl_res1", 0, 64'h0, 1);
    push_a(0, 64'h0);
    tick(); chk_a("fl_res2", 0, 64'h0, 1);
    tick(); chk_a("fl_res3", 1, 64'd8, 1);
    tick(); chk_a("fl_res4", 0, 64'h0, 0);

    // bubbles: alternate valid/invalid with the same payload
    chk_b("b_rst", 0, 32'hD503201F, 0);
    b_reset = 0; b_in_data = 32'h11;
    b_in_valid = 1; tick(); chk_b("bub1", 0, 32'hD503201F, 1);
    b_in_valid = 0; tick(); chk_b("bub2", 1, 32'h11, 1);
    b_in_valid = 1; tick(); chk_b("bub3", 0, 32'hD503201F, 1);
    b_in_valid = 0; tick(); chk_b("bub4", 1, 32'h11, 1);
    tick();                 chk_b("bub5", 0, 32'hD503201F, 0);

    // DEPTH=1: one-edge latency, stall hold, mid-stream reset
    chk_c("c_rst", 0, 8'h5A, 0);
    c_reset = 0; c_in_valid = 1; c_in_data = 8'hBB;
    tick(); chk_c("d1_cap", 1, 8'hBB, 1);
    c_in_data = 8'hCC;
    tick(); chk_c("d1_next", 1, 8'hCC, 1);
    c_stall = 1; c_in_data = 8'hDD;
    tick(); chk_c("d1_stall", 1, 8'hCC, 1);
    c_stall = 0; c_reset = 1; c_in_data = 8'hEE;
    tick(); chk_c("d1_reset", 0, 8'h5A, 0);
    c_reset = 0; c_in_valid = 0;
    tick(); chk_c("d1_idle", 0, 8'h5A, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
